// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller; the add/subtract datapath is external.
// sign_fix carries the true sign of A through the shift so M = -32768 still multiplies exactly.
module booth_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic [WIDTH-1:0]       addsub_in1,
  output logic [WIDTH-1:0]       addsub_in2,
  output logic                   addsub_oper,
  input  logic [WIDTH-1:0]       addsub_out,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EVAL  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q1_reg;
  logic [WIDTH-1:0]   m_reg;
  logic [4:0]         count_reg;
  logic               sign_fix_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic do_sub;
  logic do_op;
  logic ovf;

  assign do_sub = q_reg[0] & ~q1_reg;
  assign do_op  = q_reg[0] ^ q1_reg;

  // Signed overflow of the external add/sub, used to recover the true sign bit.
  always_comb begin
    ovf = 1'b0;
    if (do_sub)
      ovf = (a_reg[WIDTH-1] != m_reg[WIDTH-1]) && (addsub_out[WIDTH-1] != a_reg[WIDTH-1]);
    else
      ovf = (a_reg[WIDTH-1] == m_reg[WIDTH-1]) && (addsub_out[WIDTH-1] != a_reg[WIDTH-1]);
  end

  assign addsub_in1  = a_reg;
  assign addsub_in2  = m_reg;
  assign addsub_oper = do_sub;
  assign busy        = (state_reg == EVAL) || (state_reg == SHIFT);
  assign done        = (state_reg == DONE);
  assign product     = product_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      q_reg        <= '0;
      q1_reg       <= 1'b0;
      m_reg        <= '0;
      count_reg    <= '0;
      sign_fix_reg <= 1'b0;
      product_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= '0;
            q_reg     <= multiplier;
            q1_reg    <= 1'b0;
            m_reg     <= multiplicand;
            count_reg <= 5'(WIDTH);
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          if (do_op) begin
            a_reg        <= addsub_out;
            sign_fix_reg <= addsub_out[WIDTH-1] ^ ovf;
          end else begin
            sign_fix_reg <= a_reg[WIDTH-1];
          end
          state_reg <= SHIFT;
        end
        SHIFT: begin
          a_reg     <= {sign_fix_reg, a_reg[WIDTH-1:1]};
          q_reg     <= {a_reg[0], q_reg[WIDTH-1:1]};
          q1_reg    <= q_reg[0];
          count_reg <= count_reg - 5'd1;
          // Capture the post-shift value so product is valid while done is high.
          if (count_reg == 5'd1) begin
            product_reg <= {sign_fix_reg, a_reg, q_reg[WIDTH-1:1]};
            state_reg   <= DONE;
          end else begin
            state_reg <= EVAL;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width; only 16 is supported; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  16  signed M, captured on start acceptance.
REQ-006 multiplier  input  16  signed Q, captured on start acceptance.
REQ-007 addsub_in1  output  16  accumulator A, driven to the downstream add/subtract stage.
REQ-008 addsub_in2  output  16  multiplicand register M, driven to the add/subtract stage.
REQ-009 addsub_oper  output  1  1 = subtract (in1-in2), 0 = add.
REQ-010 addsub_out  input  16  combinational result from the add/subtract stage, lower 16 bits only.
REQ-011 busy  output  1  high from start acceptance until done is asserted.
REQ-012 done  output  1  one-cycle pulse when the product is valid.
REQ-013 product  output  32  signed result {A,Q}, held until the next start acceptance.

Function
REQ-014 Registers: A[15:0], Q[15:0], Q_1 (1 bit), M[15:0], count[4:0], sign_fix (1 bit), and a state register with states IDLE, EVAL, SHIFT, DONE.
REQ-015 IDLE with start=1 loads A=0, Q=multiplier, Q_1=0, M=multiplicand, count=16, and moves to EVAL; busy rises in the same edge.
REQ-016 start while not in IDLE (EVAL, SHIFT or DONE) is ignored and has no effect on any register.
REQ-017 addsub_in1=A and addsub_in2=M are driven continuously from registers, with no combinational path from inputs.
REQ-018 addsub_oper is driven as Q[0] & ~Q_1 in every state.
REQ-019 EVAL, {Q[0],Q_1}=01: A <= addsub_out (add).
REQ-020 EVAL, {Q[0],Q_1}=10: A <= addsub_out (subtract).
REQ-021 EVAL, {Q[0],Q_1}=00 or 11: A is unchanged.
REQ-022 EVAL always takes exactly one cycle, then moves to SHIFT.
REQ-023 EVAL overflow correction, for the add/sub cases: sign_fix <= addsub_out[15] XOR ovf, where ovf = (in1[15]==in2[15] && out[15]!=in1[15]) for add.
REQ-024 For subtract, ovf = (in1[15]!=in2[15] && out[15]!=in1[15]).
REQ-025 In the no-op case of EVAL, sign_fix <= A[15].
REQ-026 SHIFT performs an arithmetic right shift of {sign_fix, A, Q, Q_1}, i.e. A <= {sign_fix, A[15:1]}, Q <= {A[0], Q[15:1]}, Q_1 <= Q[0], and count <= count-1.
REQ-027 SHIFT with count==1 moves to DONE; otherwise it returns to EVAL.
REQ-028 DONE: product <= {A,Q}, done=1 for exactly one cycle, busy=0, then IDLE.
REQ-029 Latency: start accepted at edge 0 gives done high during cycle 33 (16 EVAL + 16 SHIFT), independent of operand values.
REQ-030 product updates only on entry to DONE, is stable otherwise, and keeps its old value during a new operation until the next DONE.
REQ-031 The result equals the exact signed 32-bit product for all operand pairs, including M = -32768, via the sign_fix correction.

Reset
REQ-032 rst=1 asynchronously forces state=IDLE and A=Q=M=0, Q_1=0, sign_fix=0, count=0.
REQ-033 During and after rst: product=0, busy=0, done=0, addsub_in1=0, addsub_in2=0, addsub_oper=0.
REQ-034 rst asserted mid-operation aborts it with no done pulse.
REQ-035 After release, the first start is accepted normally on the first rising edge with rst low.

Verification
REQ-036 M=3, Q=5 -> done in cycle 33, product=0x0000000F, busy high cycles 1..32.
REQ-037 M=-7 (0xFFF9), Q=6 -> product=0xFFFFFFD6 (-42); check addsub_oper toggles per Booth pairs.
REQ-038 M=-32768, Q=-32768 -> product=0x40000000.
REQ-039 M=-32768, Q=1 -> product=0xFFFF8000; also M=0x7FFF, Q=0x7FFF -> 0x3FFF0001.
REQ-040 start pulsed at cycle 10 of a run and again while done=1 -> ignored; the first result is unaffected; start the cycle after done -> accepted.
REQ-041 rst at cycle 20 of a run -> all outputs 0 immediately (asynchronous), no done pulse; a new multiply after release completes correctly.
